// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch stage and IF/ID register.
package if_id_stage_pkg;

  localparam int unsigned  INST_W        = 32;
  localparam logic [31:0]  NOP           = 32'h0000_0000;
  localparam logic [31:0]  PC_RESET_DFLT = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage with PC, IF/ID pipeline register, stall/redirect handling and debug counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DFLT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [31:0]       if_id_pc4,
  output logic [INST_W-1:0] if_id_inst,
  output logic              if_id_valid,
  output logic              id_ex_bubble,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);

  logic [31:0]       pc_q;
  logic [31:0]       pc4_q;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;
  logic [31:0]       pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect wins over stall: the stalled ID instruction is younger than the branch in EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= PC_RESET;
      pc4_q   <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (redirect) begin
      pc_q    <= redirect_target & ~32'd3;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= pc_plus4;
      pc4_q   <= pc_plus4;
      inst_q  <= imem_data;
      valid_q <= 1'b1;
    end
  end

  assign imem_addr    = pc_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_inst   = inst_q;
  assign if_id_valid  = valid_q;
  assign id_ex_bubble = stall | redirect | ~valid_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall & ~redirect),
    .count   (stall_cycles)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (redirect),
    .count   (flush_cycles)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized scoreboard bench for if_id_stage plus a wrap/saturation instance.
module tb_if_id_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  logic        reset_n2;
  logic        stall2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_data2;
  logic [31:0] if_id_pc4_2;
  logic [31:0] if_id_inst2;
  logic        if_id_valid2;
  logic        id_ex_bubble2;
  logic [3:0]  stall_cycles2;
  logic [3:0]  flush_cycles2;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
    logic        bubble;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_pc4, m_inst, m_scnt, m_fcnt;
  logic        m_valid;

  // Instruction memory contents as a fixed function of address (never zero-ish at 0).
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] sat32(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  assign imem_data  = mem_f(imem_addr);
  assign imem_data2 = mem_f(imem_addr2);

  if_id_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .if_id_pc4       (if_id_pc4),
    .if_id_inst      (if_id_inst),
    .if_id_valid     (if_id_valid),
    .id_ex_bubble    (id_ex_bubble),
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
  );

  if_id_stage #(
    .PC_RESET (32'hFFFF_FFFC),
    .CNT_W    (4)
  ) dut2 (
    .clk             (clk),
    .reset_n         (reset_n2),
    .stall           (stall2),
    .redirect        (1'b0),
    .redirect_target (32'h0),
    .imem_addr       (imem_addr2),
    .imem_data       (imem_data2),
    .if_id_pc4       (if_id_pc4_2),
    .if_id_inst      (if_id_inst2),
    .if_id_valid     (if_id_valid2),
    .id_ex_bubble    (id_ex_bubble2),
    .stall_cycles    (stall_cycles2),
    .flush_cycles    (flush_cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expected post-edge state per clock edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imem_addr", imem_addr, e.pc);
      check("if_id_pc4", if_id_pc4, e.pc4);
      check("if_id_inst", if_id_inst, e.inst);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      check("id_ex_bubble", {31'b0, id_ex_bubble}, {31'b0, e.bubble});
      check("stall_cycles", stall_cycles, e.scnt);
      check("flush_cycles", flush_cycles, e.fcnt);
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    check({tag, "_inst"}, if_id_inst, 32'h0);
    check({tag, "_pc4"}, if_id_pc4, 32'h0);
    check({tag, "_bubble"}, {31'b0, id_ex_bubble}, 32'h1);
    check({tag, "_scnt"}, stall_cycles, 32'h0);
    check({tag, "_fcnt"}, flush_cycles, 32'h0);
  endtask

  // Called and returns at a negedge; reset held 3 cycles.
  task automatic do_reset();
    reset_n  = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    check_reset_vals("rst_enter");
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
    m_pc = 32'h0; m_pc4 = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
    m_scnt = 32'h0; m_fcnt = 32'h0;
  endtask

  // Called at a negedge: drive one cycle of inputs, predict, return at the next negedge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    exp_t e;
    stall = s; redirect = r; redirect_target = t;
    #1;
    check("bubble_pre", {31'b0, id_ex_bubble}, {31'b0, (s | r | ~m_valid)});
    check("addr_pre", imem_addr, m_pc);
    if (r) begin
      m_pc = {t[31:2], 2'b00}; m_inst = 32'h0; m_valid = 1'b0; m_fcnt = sat32(m_fcnt);
    end else if (s) begin
      m_scnt = sat32(m_scnt);
    end else begin
      m_inst = mem_f(m_pc); m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1'b1;
    end
    e.pc = m_pc; e.pc4 = m_pc4; e.inst = m_inst; e.valid = m_valid;
    e.bubble = s | r | ~m_valid; e.scnt = m_scnt; e.fcnt = m_fcnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    reset_n2 = 1'b0; stall2 = 1'b0;
    @(negedge clk);
    do_reset();

    // T1: first fetch lands mem[0] with pc4=4
    step(0, 0, 0);
    check("t1_inst", if_id_inst, mem_f(32'h0));
    check("t1_pc4", if_id_pc4, 32'h4);
    // T2: stall at pc=0x10
    repeat (3) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    check("t2_addr", imem_addr, 32'h10);
    check("t2_scnt", stall_cycles, 32'd3);
    step(0, 0, 0);
    check("t2_pc4", if_id_pc4, 32'h14);
    // T3: redirect at pc=0x20 with unaligned target
    repeat (3) step(0, 0, 0);
    step(0, 1, 32'h0000_0103);
    check("t3_addr", imem_addr, 32'h100);
    check("t3_fcnt", flush_cycles, 32'd1);
    step(0, 0, 0);
    check("t3_inst", if_id_inst, mem_f(32'h100));
    // T4: redirect and stall together
    step(1, 1, 32'h40);
    check("t4_addr", imem_addr, 32'h40);
    check("t4_fcnt", flush_cycles, 32'd2);
    check("t4_scnt", stall_cycles, 32'd3);
    step(1, 1, 32'h80);
    step(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic s, r;
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 15);
      step(s, r, $urandom());
    end

    // T6: async reset between edges during a stall
    step(1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    @(negedge clk);
    do_reset();
    repeat (5) step(0, 0, 0);

    // T5: wrap and saturation on the narrow instance
    check("t5_addr_rst", imem_addr2, 32'hFFFF_FFFC);
    reset_n2 = 1'b1;
    @(negedge clk);
    check("t5_wrap_addr", imem_addr2, 32'h0);
    check("t5_wrap_pc4", if_id_pc4_2, 32'h0);
    check("t5_inst", if_id_inst2, mem_f(32'hFFFF_FFFC));
    stall2 = 1'b1;
    repeat (14) @(negedge clk);
    check("t5_cnt14", {28'b0, stall_cycles2}, 32'd14);
    repeat (6) @(negedge clk);
    check("t5_sat", {28'b0, stall_cycles2}, 32'hF);
    check("t5_hold_addr", imem_addr2, 32'h0);
    stall2 = 1'b0;

    @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
